// File: rtl/key_pkg.sv
// Shared types and default timing for the push-button conditioner.
// No logic; no latency.
// No flow control; constants only.
package key_pkg;

    // Per-channel debounce FSM states.
    typedef enum logic [1:0] {
        UP     = 2'd0,
        DEB_DN = 2'd1,
        DOWN   = 2'd2,
        DEB_UP = 2'd3
    } key_state_t;

    // Defaults for a 50 MHz board clock.
    localparam int DEF_NUM_KEYS        = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;   // 20 ms
    localparam int DEF_HOLD_CYCLES     = 50_000_000;  // 1 s

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop sync, debounce FSM, level/press/release/toggle/hold outputs.
// Latency: press/level 2+DEBOUNCE_CYCLES cycles after a stable raw edge; hold at press+HOLD_CYCLES-1.
// No backpressure; outputs are registered pulses/levels.
//
// Ports: clk, reset (async, active-high), key_n (raw, active-low),
//        key_level_n, key_press, key_release, key_toggle, key_hold.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic key_level_n,
    output logic key_press,
    output logic key_release,
    output logic key_toggle,
    output logic key_hold
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    logic            sync1;
    logic            sync2;
    key_state_t      state;
    key_state_t      state_nxt;
    logic [DW-1:0]   deb_cnt;
    logic [DW-1:0]   deb_cnt_nxt;
    logic [HW-1:0]   hold_cnt;
    logic [HW-1:0]   hold_cnt_nxt;
    logic            hold_fired;
    logic            hold_fired_nxt;
    logic            press_nxt;
    logic            release_nxt;
    logic            hold_nxt;

    // Both sync flops reset to "released" so reset never looks like a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    always_comb begin
        state_nxt      = state;
        deb_cnt_nxt    = deb_cnt;
        hold_cnt_nxt   = hold_cnt;
        hold_fired_nxt = hold_fired;
        press_nxt      = 1'b0;
        release_nxt    = 1'b0;
        hold_nxt       = 1'b0;

        // Hold timer runs while the key is logically down (including a pending
        // release) and stops once it has fired, so it never wraps.
        if ((state == DOWN || state == DEB_UP) && !hold_fired) begin
            hold_cnt_nxt = hold_cnt + 1'b1;
            if (hold_cnt_nxt == HOLD_LAST) begin
                hold_nxt       = 1'b1;
                hold_fired_nxt = 1'b1;
            end
        end

        // The first low sample counts as sample 0, so acceptance happens on the
        // DEBOUNCE_CYCLES-th consecutive stable sample.
        case (state)
            UP: begin
                if (!sync2) begin
                    state_nxt   = DEB_DN;
                    deb_cnt_nxt = '0;
                end
            end
            DEB_DN: begin
                if (sync2) begin
                    state_nxt   = UP;
                    deb_cnt_nxt = '0;
                end else begin
                    deb_cnt_nxt = deb_cnt + 1'b1;
                    if (deb_cnt_nxt == DEB_LAST) begin
                        state_nxt      = DOWN;
                        deb_cnt_nxt    = '0;
                        press_nxt      = 1'b1;
                        hold_cnt_nxt   = '0;
                        hold_fired_nxt = 1'b0;
                    end
                end
            end
            DOWN: begin
                if (sync2) begin
                    state_nxt   = DEB_UP;
                    deb_cnt_nxt = '0;
                end
            end
            DEB_UP: begin
                if (!sync2) begin
                    // Release bounce: hold timing continues uninterrupted.
                    state_nxt   = DOWN;
                    deb_cnt_nxt = '0;
                end else begin
                    deb_cnt_nxt = deb_cnt + 1'b1;
                    if (deb_cnt_nxt == DEB_LAST) begin
                        state_nxt      = UP;
                        deb_cnt_nxt    = '0;
                        release_nxt    = 1'b1;
                        hold_cnt_nxt   = '0;
                        hold_fired_nxt = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt   = UP;
                deb_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= UP;
            deb_cnt     <= '0;
            hold_cnt    <= '0;
            hold_fired  <= 1'b0;
            key_level_n <= 1'b1;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_toggle  <= 1'b0;
            key_hold    <= 1'b0;
        end else begin
            state       <= state_nxt;
            deb_cnt     <= deb_cnt_nxt;
            hold_cnt    <= hold_cnt_nxt;
            hold_fired  <= hold_fired_nxt;
            key_level_n <= !(state_nxt == DOWN || state_nxt == DEB_UP);
            key_press   <= press_nxt;
            key_release <= release_nxt;
            key_toggle  <= key_toggle ^ press_nxt;
            key_hold    <= hold_nxt;
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Push-button front end: NUM_KEYS independent debounce channels for the stopwatch controls.
// Latency: 2+DEBOUNCE_CYCLES cycles from a stable raw edge to press/release; hold at press+HOLD_CYCLES-1.
// No backpressure; all outputs are registered levels or one-cycle pulses in the clk domain.
//
// Ports: clk, reset (async, active-high), key_n[NUM_KEYS] raw active-low keys;
//        key_level_n, key_press, key_release, key_toggle, key_hold per key.
// DEBOUNCE_CYCLES must be 2..2^24 and HOLD_CYCLES must exceed DEBOUNCE_CYCLES.
module key_conditioner
    import key_pkg::*;
#(
    parameter int NUM_KEYS        = DEF_NUM_KEYS,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level_n,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_toggle,
    output logic [NUM_KEYS-1:0] key_hold
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .key_n       (key_n[i]),
            .key_level_n (key_level_n[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_toggle  (key_toggle[i]),
            .key_hold    (key_hold[i])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner with short debounce/hold timing.
// Reference model tracks each key as an accepted level plus a run length of
// disagreeing synchronised samples, and a count of cycles since press.
module tb_key_conditioner;

    localparam int NK = 4;
    localparam int D  = 8;
    localparam int H  = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_level_n;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NK-1:0] key_toggle;
    logic [NK-1:0] key_hold;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    key_conditioner #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_n       (key_n),
        .key_level_n (key_level_n),
        .key_press   (key_press),
        .key_release (key_release),
        .key_toggle  (key_toggle),
        .key_hold    (key_hold)
    );

    // ---------------- reference model ----------------
    logic [NK-1:0] m_d1, m_d2, m_lvl, m_tog, m_press, m_rel, m_hold, m_fired;
    int            m_run  [NK];
    int            m_hcnt [NK];
    logic          m_s;

    always @(posedge clk) cyc++;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_d1 = '1; m_d2 = '1; m_lvl = '1; m_tog = '0;
            m_press = '0; m_rel = '0; m_hold = '0; m_fired = '0;
            for (int k = 0; k < NK; k++) begin
                m_run[k]  = 0;
                m_hcnt[k] = 0;
            end
        end else begin
            for (int k = 0; k < NK; k++) begin
                m_s        = m_d2[k];
                m_press[k] = 1'b0;
                m_rel[k]   = 1'b0;
                m_hold[k]  = 1'b0;
                // cycles since press, while logically down
                if (!m_lvl[k] && !m_fired[k]) begin
                    m_hcnt[k]++;
                    if (m_hcnt[k] == H - 1) begin
                        m_hold[k]  = 1'b1;
                        m_fired[k] = 1'b1;
                    end
                end
                // accept a new level after D consecutive disagreeing samples
                if (m_s != m_lvl[k]) begin
                    m_run[k]++;
                    if (m_run[k] == D) begin
                        m_lvl[k]   = m_s;
                        m_run[k]   = 0;
                        m_hcnt[k]  = 0;
                        m_fired[k] = 1'b0;
                        if (!m_s) begin
                            m_press[k] = 1'b1;
                            m_tog[k]   = ~m_tog[k];
                        end else begin
                            m_rel[k] = 1'b1;
                        end
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            m_d2 = m_d1;
            m_d1 = key_n;
        end
    end

    wire [5*NK-1:0] dut_vec = {key_level_n, key_press, key_release, key_toggle, key_hold};
    wire [5*NK-1:0] mdl_vec = {m_lvl, m_press, m_rel, m_tog, m_hold};

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        key_n = '1;
        repeat (3) @(negedge clk);
        checks++;
        if (key_level_n !== {NK{1'b1}}) begin
            errors++; $display("FAIL reset_level: got %b expected %b", key_level_n, {NK{1'b1}});
        end
        checks++;
        if ({key_press, key_release, key_toggle, key_hold} !== {4*NK{1'b0}}) begin
            errors++; $display("FAIL reset_pulses: got %h expected 0", {key_press, key_release, key_toggle, key_hold});
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (dut_vec !== mdl_vec) begin
            errors++; $display("FAIL idle_after_reset: got %h expected %h", dut_vec, mdl_vec);
        end
    endtask

    task automatic test_clean_press();
        int t0, p_cyc, r_cyc, n_press, n_rel, n_hold, bad;
        logic lvl9, lvl10;
        p_cyc = -1; r_cyc = -1; n_press = 0; n_rel = 0; n_hold = 0; bad = 0;
        lvl9 = 1'bx; lvl10 = 1'bx;
        @(negedge clk);
        key_n[0] = 1'b0;
        t0 = cyc;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (dut_vec !== mdl_vec) bad++;
            if (key_press[0])   begin n_press++; p_cyc = cyc; end
            if (key_release[0]) begin n_rel++;   r_cyc = cyc; end
            if (key_hold[0])    n_hold++;
            if (cyc == t0 + 9)  lvl9  = key_level_n[0];
            if (cyc == t0 + 10) lvl10 = key_level_n[0];
            if (i == 20) key_n[0] = 1'b1;
        end
        checks++;
        if (n_press != 1) begin errors++; $display("FAIL clean_press_count: got %0d expected 1", n_press); end
        checks++;
        if (p_cyc != t0 + 10) begin errors++; $display("FAIL clean_press_cycle: got %0d expected %0d", p_cyc, t0 + 10); end
        checks++;
        if (lvl9 !== 1'b1 || lvl10 !== 1'b0) begin
            errors++; $display("FAIL clean_level_edge: got %b%b expected 10", lvl9, lvl10);
        end
        checks++;
        if (n_hold != 0) begin errors++; $display("FAIL clean_no_hold: got %0d expected 0", n_hold); end
        checks++;
        if (n_rel != 1 || r_cyc != t0 + 30) begin
            errors++; $display("FAIL clean_release: got count %0d cycle %0d expected 1 at %0d", n_rel, r_cyc, t0 + 30);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL clean_model: got %0d mismatching cycles expected 0", bad); end
    endtask

    task automatic test_bounce();
        int tl, p_cyc, n_press, bad;
        p_cyc = -1; n_press = 0; bad = 0; tl = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (dut_vec !== mdl_vec) bad++;
            if (key_press[0]) begin n_press++; p_cyc = cyc; end
            // five 3-cycle low bursts separated by 3-cycle highs, then steady low
            if (i < 30)      key_n[0] = ((i / 3) % 2) == 1;
            else if (i < 50) key_n[0] = 1'b0;
            else             key_n[0] = 1'b1;
            if (i == 30) tl = cyc;
        end
        checks++;
        if (n_press != 1) begin errors++; $display("FAIL bounce_press_count: got %0d expected 1", n_press); end
        checks++;
        if (p_cyc != tl + 10) begin errors++; $display("FAIL bounce_press_cycle: got %0d expected %0d", p_cyc, tl + 10); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL bounce_model: got %0d mismatching cycles expected 0", bad); end
    endtask

    task automatic test_hold();
        int t0, n_hold, n_press, h1, h2, bad;
        n_hold = 0; n_press = 0; h1 = -1; h2 = -1; bad = 0; t0 = 0;
        for (int i = 0; i < 170; i++) begin
            @(negedge clk);
            if (dut_vec !== mdl_vec) bad++;
            if (key_press[0]) n_press++;
            if (key_hold[0]) begin
                n_hold++;
                if (n_hold == 1) h1 = cyc; else h2 = cyc;
            end
            key_n[0] = !((i < 60) || (i >= 85 && i < 145));
            if (i == 0) t0 = cyc;
        end
        checks++;
        if (n_hold != 2 || n_press != 2) begin
            errors++; $display("FAIL hold_counts: got holds %0d presses %0d expected 2 and 2", n_hold, n_press);
        end
        checks++;
        if (h1 != t0 + 41) begin errors++; $display("FAIL hold_first_cycle: got %0d expected %0d", h1, t0 + 41); end
        checks++;
        if (h2 != t0 + 126) begin errors++; $display("FAIL hold_rearm_cycle: got %0d expected %0d", h2, t0 + 126); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL hold_model: got %0d mismatching cycles expected 0", bad); end
    endtask

    task automatic test_toggle();
        logic [2:0] seq;
        logic [2:0] others0;
        int         n, other_press, bad;
        n = 0; other_press = 0; bad = 0; seq = '0;
        others0 = {key_toggle[3:2], key_toggle[0]};
        for (int i = 0; i < 98; i++) begin
            @(negedge clk);
            if (dut_vec !== mdl_vec) bad++;
            if (key_press[1]) begin
                if (n < 3) seq[n] = key_toggle[1];
                n++;
            end
            if (key_press[0] || key_press[2] || key_press[3]) other_press++;
            key_n[1] = (i < 84) ? (((i / 14) % 2) == 1) : 1'b1;
        end
        checks++;
        if (n != 3 || seq !== 3'b101) begin
            errors++; $display("FAIL toggle_sequence: got %0d presses seq(2..0) %b expected 3 and 101", n, seq);
        end
        checks++;
        if ({key_toggle[3:2], key_toggle[0]} !== others0 || other_press != 0) begin
            errors++; $display("FAIL toggle_isolation: got %b presses %0d expected %b and 0",
                               {key_toggle[3:2], key_toggle[0]}, other_press, others0);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL toggle_model: got %0d mismatching cycles expected 0", bad); end
    endtask

    task automatic test_simultaneous();
        logic [NK-1:0] tog0, p9, p10, r30;
        int bad;
        bad = 0; p9 = 'x; p10 = 'x; r30 = 'x;
        tog0 = key_toggle;
        @(negedge clk);
        key_n = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (dut_vec !== mdl_vec) bad++;
            if (i == 9)  p9  = key_press;
            if (i == 10) p10 = key_press;
            if (i == 30) r30 = key_release;
            if (i == 20) key_n = '1;
        end
        checks++;
        if (p9 !== '0 || p10 !== {NK{1'b1}}) begin
            errors++; $display("FAIL simul_press: got %b then %b expected 0000 then 1111", p9, p10);
        end
        checks++;
        if (r30 !== {NK{1'b1}}) begin errors++; $display("FAIL simul_release: got %b expected 1111", r30); end
        checks++;
        if (key_toggle !== ~tog0) begin errors++; $display("FAIL simul_toggle: got %b expected %b", key_toggle, ~tog0); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL simul_model: got %0d mismatching cycles expected 0", bad); end
    endtask

    task automatic test_reset_mid();
        logic lvl_down;
        int   p_cyc, n_press, n_other, t0, bad;
        p_cyc = -1; n_press = 0; n_other = 0; bad = 0;
        @(negedge clk);
        key_n[2] = 1'b0;
        repeat (14) @(negedge clk);
        lvl_down = key_level_n[2];
        checks++;
        if (lvl_down !== 1'b0) begin errors++; $display("FAIL resetmid_down: got %b expected 0", lvl_down); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (key_level_n !== {NK{1'b1}} || {key_press, key_release, key_toggle, key_hold} !== {4*NK{1'b0}}) begin
            errors++; $display("FAIL resetmid_immediate: got lvl %b rest %h expected 1111 and 0",
                               key_level_n, {key_press, key_release, key_toggle, key_hold});
        end
        @(negedge clk);
        reset = 1'b0;
        t0 = cyc;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (dut_vec !== mdl_vec) bad++;
            if (key_press[2]) begin n_press++; p_cyc = cyc; end
            if (key_press[0] || key_press[1] || key_press[3]) n_other++;
            if (i == 20) key_n[2] = 1'b1;
        end
        checks++;
        if (n_press != 1 || p_cyc != t0 + 10 || n_other != 0) begin
            errors++; $display("FAIL resetmid_repress: got count %0d cycle %0d others %0d expected 1 at %0d and 0",
                               n_press, p_cyc, n_other, t0 + 10);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL resetmid_model: got %0d mismatching cycles expected 0", bad); end
    endtask

    task automatic test_random();
        int remain [NK];
        int bad, dut_p, mdl_p, dut_h, mdl_h;
        bad = 0; dut_p = 0; mdl_p = 0; dut_h = 0; mdl_h = 0;
        for (int k = 0; k < NK; k++) remain[k] = $urandom_range(1, 20);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (dut_vec !== mdl_vec) bad++;
            dut_p += $countones(key_press);
            mdl_p += $countones(m_press);
            dut_h += $countones(key_hold);
            mdl_h += $countones(m_hold);
            for (int k = 0; k < NK; k++) begin
                remain[k]--;
                if (remain[k] <= 0) begin
                    key_n[k] = ~key_n[k];
                    // mostly short bounces, sometimes long enough to accept or hold
                    remain[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(9, 60) : $urandom_range(1, 10);
                end
            end
        end
        key_n = '1;
        repeat (15) @(negedge clk);
        checks++;
        if (bad != 0) begin errors++; $display("FAIL random_model: got %0d mismatching cycles expected 0", bad); end
        checks++;
        if (dut_p != mdl_p || dut_h != mdl_h) begin
            errors++; $display("FAIL random_counts: got presses %0d holds %0d expected %0d and %0d",
                               dut_p, dut_h, mdl_p, mdl_h);
        end
        checks++;
        if (dut_vec !== mdl_vec) begin
            errors++; $display("FAIL random_idle: got %h expected %h", dut_vec, mdl_vec);
        end
    endtask

    initial begin
        reset = 1'b1;
        key_n = '1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_hold();
        test_toggle();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
